decoder_scan: RTL
=================

DECODER_SCAN -- requirements
Module: decoder_scan

Interface
REQ-001 Parameter N, default 3: select/address width; output width is 2**N, and N shall be 1..6.
REQ-002 Parameter SCAN_DIV, default 4: clock cycles per scan step; SCAN_DIV shall be >= 1.
REQ-003 clk  input  1  single clock; all state shall update on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 en  input  1  block enable.
REQ-006 mode  input  1  0 = direct decode, 1 = auto-scan.
REQ-007 load  input  1  capture strobe for A.
REQ-008 A  input  N  address to decode.
REQ-009 Y  output  2**N  registered one-hot decode of sel, or all-zero.
REQ-010 sel  output  N  current registered select index.
REQ-011 valid  output  1  registered; Y carries a legal one-hot value.
REQ-012 wrap  output  1  one-cycle pulse when a scan step wraps 2**N-1 -> 0.

Function
REQ-013 State shall be sel (N bits), a prescaler pcnt (counting 0..SCAN_DIV-1), Y, valid and wrap.
REQ-014 All outputs shall be registered, with no combinational path from any input to any output.
REQ-015 Each edge: Y_next shall equal (1 << sel_next) when en=1, and all-zero when en=0.
REQ-016 Each edge: valid_next shall equal en.
REQ-017 The Y update rule shall hold Y one-hot, with only bit sel set, whenever valid=1.
REQ-018 Priority per edge shall be: en=0, then load, then scan step, then hold.
REQ-019 en=0:
  - sel holds.
  - pcnt clears to 0.
  - wrap=0.
  - load is ignored.
REQ-020 en=1 and load=1, either mode:
  - sel_next=A.
  - pcnt clears to 0.
  - wrap=0.
  - Y shows onehot(A) one cycle after the load edge (latency 1).
REQ-021 en=1, load=0, mode=0: sel and pcnt shall hold, and wrap=0.
REQ-022 en=1, load=0, mode=1, pcnt<SCAN_DIV-1: pcnt shall increment and sel shall hold.
REQ-023 en=1, load=0, mode=1, pcnt=SCAN_DIV-1:
  - pcnt returns to 0.
  - sel increments modulo 2**N.
REQ-024 wrap_next shall be 1 only on a REQ-023 step where sel=2**N-1 (wrap-around to 0); otherwise wrap_next=0.
REQ-025 SCAN_DIV=1: sel shall advance every enabled cycle, and wrap shall pulse once every 2**N cycles.
REQ-026 A mode change shall not alter sel.
REQ-027 A 0->1 mode change shall scan from the current sel with pcnt as left by direct mode (0 or held).
REQ-028 A 1->0 mode change shall freeze sel and pcnt at their current values.
REQ-029 Enable after disable shall resume with Y=onehot(held sel) one cycle after en rises.
REQ-030 A in scan mode shall matter only on load edges.
REQ-031 Arithmetic shall be unsigned.
REQ-032 pcnt width shall be clog2(SCAN_DIV), minimum 1 bit.
REQ-033 sel shall wrap naturally at N bits.

Reset
REQ-034 rst_n=0 shall immediately, without waiting for a clock edge, force:
  - sel=0, pcnt=0.
  - Y=all-zero.
  - valid=0, wrap=0.
REQ-035 Reset asserted mid-scan shall abandon the step in progress.
REQ-036 After release, the first edge shall follow REQ-015..024 from the reset state.
REQ-037 Release shall be synchronous-safe: the first edge after rst_n rises shall be the first active edge.

Verification (N=3, SCAN_DIV=4)
REQ-038 Direct decode: en=1, mode=0, load=1, A=5 for one cycle -> next cycle sel=5, Y=8'b0010_0000, valid=1; after load drops, Y holds for 10 cycles.
REQ-039 Scan: en=1, mode=1 from sel=0, pcnt=0 -> sel steps 1,2,...,7,0, each step 4 cycles apart; wrap=1 for exactly one cycle, coincident with sel=0 and Y=8'b0000_0001.
REQ-040 Load in scan: mode=1, sel=3 with pcnt=2, load=1, A=6 -> next cycle sel=6, pcnt=0; the next step to 7 comes 4 cycles later; no wrap pulse.
REQ-041 Disable: during scan at sel=4, en=0 for 3 cycles -> Y=0 and valid=0 the next cycle, sel stays 4; on en=1 -> Y=8'b0001_0000 one cycle later, and the step to 5 comes 4 cycles after re-enable.
REQ-042 Async reset: mid-scan at sel=7, pcnt=3, rst_n pulsed low between edges -> Y=0, sel=0, valid=0, wrap=0 before the next edge; no wrap pulse afterwards.
REQ-043 SCAN_DIV=1 build: en=1, mode=1 -> sel increments every cycle, wrap pulses every 8th cycle, and Y is always one-hot.

Source files
------------

// File: rtl/decoder_scan.sv
// -----------------------------------------------------------------------------
// decoder_scan
//
// N-to-2**N one-hot decoder with an optional auto-scan mode. The decoded
// index sel is either loaded from A or, in scan mode, advanced by one every
// SCAN_DIV enabled clock cycles. All outputs are registered.
//
// Legal parameter ranges: 1 <= N <= 6, SCAN_DIV >= 1.
//
// Ports
//   clk    in   single clock, rising edge
//   rst_n  in   asynchronous active-low reset
//   en     in   block enable; when low, Y/valid clear and sel holds
//   mode   in   0 = direct decode, 1 = auto-scan
//   load   in   capture strobe: sel <= A (has priority over scanning)
//   A      in   [N-1:0] address to decode
//   Y      out  [2**N-1:0] one-hot decode of sel, or all-zero when disabled
//   sel    out  [N-1:0] current select index
//   valid  out  Y carries a legal one-hot value
//   wrap   out  one-cycle pulse when a scan step wraps 2**N-1 -> 0
//
// Per-edge priority: en=0, then load, then scan step, then hold.
// -----------------------------------------------------------------------------
module decoder_scan #(
    parameter int N        = 3,
    parameter int SCAN_DIV = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              mode,
    input  logic              load,
    input  logic [N-1:0]      A,
    output logic [2**N-1:0]   Y,
    output logic [N-1:0]      sel,
    output logic              valid,
    output logic              wrap
);

    localparam int W  = 2**N;
    // A divide-by-1 prescaler still gets a 1-bit counter that never leaves 0.
    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    localparam logic [PW-1:0] PCNT_LAST = PW'(SCAN_DIV - 1);
    localparam logic [N-1:0]  SEL_LAST  = {N{1'b1}};

    logic [N-1:0]  sel_q,   sel_d;
    logic [PW-1:0] pcnt_q,  pcnt_d;
    logic [W-1:0]  y_q,     y_d;
    logic          valid_q, valid_d;
    logic          wrap_q,  wrap_d;

    // Next-state for the select index and prescaler.
    always_comb begin
        sel_d  = sel_q;
        pcnt_d = pcnt_q;
        wrap_d = 1'b0;
        if (!en) begin
            // Disabled: sel frozen, prescaler restarts so a re-enabled scan
            // gets a full SCAN_DIV period before its next step.
            pcnt_d = '0;
        end else if (load) begin
            sel_d  = A;
            pcnt_d = '0;
        end else if (mode) begin
            if (pcnt_q == PCNT_LAST) begin
                pcnt_d = '0;
                sel_d  = sel_q + N'(1);
                wrap_d = (sel_q == SEL_LAST);
            end else begin
                pcnt_d = pcnt_q + PW'(1);
            end
        end
        // mode=0 without load: sel and pcnt hold (defaults).
    end

    // Decode the *next* sel so Y and sel change on the same edge.
    always_comb begin
        y_d     = '0;
        valid_d = en;
        if (en) begin
            y_d[sel_d] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_q   <= '0;
            pcnt_q  <= '0;
            y_q     <= '0;
            valid_q <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            sel_q   <= sel_d;
            pcnt_q  <= pcnt_d;
            y_q     <= y_d;
            valid_q <= valid_d;
            wrap_q  <= wrap_d;
        end
    end

    assign Y     = y_q;
    assign sel   = sel_q;
    assign valid = valid_q;
    assign wrap  = wrap_q;

endmodule
